mvm_requant_stage: RTL and testbench
====================================

Name: mvm_requant_stage

Overview:
- Downstream neighbour of matvec3_part1; consumes its 28-bit signed y stream through a valid/ready handshake.
- Per element: optional ReLU, rounding arithmetic right shift, saturation to 14-bit signed.
- Buffers results in a small FIFO and emits them as the next layer's 14-bit input stream, tagging the last element of each output vector.

Parameters:
- IN_W, 28, input sample width (signed)
- OUT_W, 14, output sample width (signed)
- SHIFT, 2, right-shift amount, 0..IN_W-1; rounding applies only when SHIFT>0
- RELU_EN, 1, 1 = clamp negative inputs to 0 before shifting
- VEC_LEN, 3, elements per vector; drives output_last
- DEPTH, 4, FIFO entries, power of 2, >=2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- input_valid  in  1  upstream data valid
- input_ready  out  1  block can accept data this cycle
- input_data  in  IN_W  signed y from matvec3_part1
- output_valid  out  1  output_data valid
- output_ready  in  1  downstream can accept
- output_data  out  OUT_W  signed requantized value
- output_last  out  1  element is the VEC_LEN-th of its vector
- output_sat  out  1  element was clipped by saturation

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; group counter = 0.
  - input_ready=0, output_valid=0, output_data=0, output_last=0, output_sat=0.
- Reset release: input_ready=1 after the first rising edge with reset=1.
- Input accept:
  - Accept happens on a rising edge with input_valid && input_ready.
  - input_data is ignored (may be X) when input_valid=0.
- input_ready is registered: 1 iff FIFO occupancy after this edge < DEPTH.
  - No pass-through when full; a simultaneous pop does not raise ready in the same cycle.
- Datapath (combinational on input_data, written to FIFO at accept), with v = input_data:
  1. If RELU_EN and v<0, v = 0.
  2. If SHIFT>0, r = (v + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits so no overflow; rounds half toward +inf. If SHIFT=0, r = v.
  3. If r > 2^(OUT_W-1)-1, out = 8191 and sat=1. If r < -2^(OUT_W-1), out = -8192 and sat=1. Otherwise out = r[OUT_W-1:0] and sat=0.
- Group counter:
  - Increments on each accept; wraps VEC_LEN-1 -> 0.
  - The last bit stored with an entry = (counter == VEC_LEN-1) at accept.
- FIFO entry = {out, last, sat}; storage is in-order, no reordering or drops.
- Output:
  - output_* present the FIFO head; output_valid = FIFO non-empty.
  - Latency: an element accepted at edge N is visible at output after edge N (output_valid=1 in cycle N+1 if the FIFO was empty).
  - Pop happens on a rising edge with output_valid && output_ready.
  - output_data/last/sat are stable while output_valid=1 and output_ready=0.
- Simultaneous push and pop: occupancy unchanged; both succeed.
- Empty: output_valid=0 and output_data holds the last value (don't-care to downstream).
- Full: input_ready=0 until a pop; it rises the cycle after the pop edge.
- Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Reset mid-stream: all in-flight entries are discarded and the group counter restarts at 0. The first element after reset is element 0 of a new vector.

Test Plan:
1. Defaults; input -800, -1200, 8400 with output_ready=1 -> outputs 0, 0, 2100; output_last = 0, 0, 1; output_sat = 0, 0, 0.
2. RELU_EN=0, SHIFT=2; input 6, 5, -6, 40000, -40000, 0 -> outputs 2, 1, -1, 8191 (sat=1), -8192 (sat=1), 0; output_last=1 on the 3rd and 6th elements.
3. Backpressure: output_ready=0, offer 5 values 1..5 (SHIFT=0) -> exactly 4 accepted and input_ready=0. Raise output_ready -> outputs 1, 2, 3, 4, then 5 accepted and output in order; input_ready returns to 1 one cycle after the first pop.
4. Random input_valid and output_ready each cycle over 12 consecutive y values (4 vectors) -> every value output exactly once, in order; last asserted on elements 3, 6, 9, 12; no output_valid after the final pop.
5. Drive reset=0 asynchronously (mid-cycle) with 3 entries queued and the group counter at 1 -> outputs go to 0 immediately, without waiting for a clock edge. After release, push 3 values -> only those 3 appear, with last on the 3rd.
6. Push and pop on the same edge while FIFO holds 2 entries -> occupancy stays 2; input_ready stays 1; data order preserved.

Source files
------------

// File: rtl/mvm_requant_stage_if.sv
// Stream bundle between matvec3_part1 (28-bit y) and the next layer (14-bit requantized x).
interface mvm_requant_stage_if #(
    parameter int IN_W  = 28,
    parameter int OUT_W = 14
);
    logic                    input_valid;
    logic                    input_ready;
    logic signed [IN_W-1:0]  input_data;
    logic                    output_valid;
    logic                    output_ready;
    logic signed [OUT_W-1:0] output_data;
    logic                    output_last;
    logic                    output_sat;

    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_data, output_last, output_sat
    );

    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_data, output_last, output_sat
    );
endinterface

// File: rtl/mvm_requant_stage.sv
// Requantizes matvec y samples (ReLU, rounding shift, saturation) into a small FIFO
// and streams them out as 14-bit elements with a per-vector last tag.
module mvm_requant_stage #(
    parameter int IN_W    = 28,
    parameter int OUT_W   = 14,
    parameter int SHIFT   = 2,
    parameter int RELU_EN = 1,
    parameter int VEC_LEN = 3,
    parameter int DEPTH   = 4
) (
    input logic               clk,
    input logic               reset,
    mvm_requant_stage_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int EW  = OUT_W + 2;
    localparam int CW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

    logic signed [IN_W-1:0]  v;
    logic signed [IN_W:0]    vx;
    logic signed [IN_W:0]    r;
    logic signed [OUT_W-1:0] q;
    logic                    sat;
    logic                    last;

    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;
    logic [EW-1:0]   hold;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_nxt;
    logic [CW-1:0]   grp;
    logic            in_rdy;
    logic            push;
    logic            pop;

    always_comb begin
        v = bus.input_data;
        if (RELU_EN != 0 && v[IN_W-1]) begin
            v = '0;
        end
    end

    // One extra bit of headroom so the rounding add can never wrap.
    assign vx = $signed({v[IN_W-1], v});

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT-1);
            assign r = (vx + RND) >>> SHIFT;
        end else begin : g_pass
            assign r = vx;
        end
    endgenerate

    always_comb begin
        q   = r[OUT_W-1:0];
        sat = 1'b0;
        if (r > SAT_MAX) begin
            q   = SAT_MAX[OUT_W-1:0];
            sat = 1'b1;
        end else if (r < SAT_MIN) begin
            q   = SAT_MIN[OUT_W-1:0];
            sat = 1'b1;
        end
    end

    assign last      = (grp == CW'(VEC_LEN-1));
    assign push      = bus.input_valid && in_rdy;
    assign pop       = bus.output_valid && bus.output_ready;
    assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            grp    <= '0;
            in_rdy <= 1'b0;
            hold   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {q, last, sat};
                wr_ptr      <= wr_ptr + AW'(1);
                grp         <= last ? '0 : grp + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold   <= head;
            end
            count  <= count_nxt;
            in_rdy <= (count_nxt < (AW+1)'(DEPTH));
        end
    end

    // Once drained, the last popped entry stays on the output rather than a stale slot.
    assign head             = (count != '0) ? mem[rd_ptr] : hold;
    assign bus.input_ready  = in_rdy;
    assign bus.output_valid = (count != '0);
    assign bus.output_data  = head[EW-1:2];
    assign bus.output_last  = head[1];
    assign bus.output_sat   = head[0];
endmodule

// File: tb/tb_mvm_requant_stage.sv
// Scoreboard bench for three mvm_requant_stage configurations sharing one clock and reset.
`timescale 1ns/1ps
module tb_mvm_requant_stage;
    typedef struct {
        logic signed [13:0] d;
        logic               l;
        logic               s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    bit drv_done;

    always #5 clk = ~clk;

    mvm_requant_stage_if ifa ();
    mvm_requant_stage_if ifb ();
    mvm_requant_stage_if ifc ();

    mvm_requant_stage u_a (.clk(clk), .reset(rst), .bus(ifa));
    mvm_requant_stage #(.RELU_EN(0), .SHIFT(2)) u_b (.clk(clk), .reset(rst), .bus(ifb));
    mvm_requant_stage #(.SHIFT(0)) u_c (.clk(clk), .reset(rst), .bus(ifc));

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int s);
        case (s)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic logic in_rdy(input int s);
        case (s)
            0:       return ifa.input_ready;
            1:       return ifb.input_ready;
            default: return ifc.input_ready;
        endcase
    endfunction

    function automatic logic out_vld(input int s);
        case (s)
            0:       return ifa.output_valid;
            1:       return ifb.output_valid;
            default: return ifc.output_valid;
        endcase
    endfunction

    task automatic set_in(input int s, input logic vld, input logic signed [27:0] d);
        case (s)
            0:       begin ifa.input_valid = vld; ifa.input_data = d; end
            1:       begin ifb.input_valid = vld; ifb.input_data = d; end
            default: begin ifc.input_valid = vld; ifc.input_data = d; end
        endcase
    endtask

    task automatic set_ordy(input int s, input logic r);
        case (s)
            0:       ifa.output_ready = r;
            1:       ifb.output_ready = r;
            default: ifc.output_ready = r;
        endcase
    endtask

    task automatic check_out(input int s, input logic signed [13:0] d, input logic l, input logic st);
        exp_t e;
        vectors++;
        if (qsize(s) == 0) begin
            miscompares++;
            $display("FAIL out%0d_unexpected: got data=%0d last=%0b sat=%0b expected nothing", s, d, l, st);
        end else begin
            case (s)
                0:       e = qa.pop_front();
                1:       e = qb.pop_front();
                default: e = qc.pop_front();
            endcase
            if (d !== e.d || l !== e.l || st !== e.s) begin
                miscompares++;
                $display("FAIL out%0d_element: got data=%0d last=%0b sat=%0b expected data=%0d last=%0b sat=%0b",
                         s, d, l, st, e.d, e.l, e.s);
            end
        end
    endtask

    always @(negedge clk) if (ifa.output_valid && ifa.output_ready)
        check_out(0, ifa.output_data, ifa.output_last, ifa.output_sat);
    always @(negedge clk) if (ifb.output_valid && ifb.output_ready)
        check_out(1, ifb.output_data, ifb.output_last, ifb.output_sat);
    always @(negedge clk) if (ifc.output_valid && ifc.output_ready)
        check_out(2, ifc.output_data, ifc.output_last, ifc.output_sat);

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive(input int s, input logic signed [27:0] d, input logic signed [13:0] ed,
                         input logic el, input logic es);
        exp_t e;
        int   n = 0;
        bit   done = 0;
        e.d = ed; e.l = el; e.s = es;
        set_in(s, 1'b1, d);
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_rdy(s)) begin
                case (s)
                    0:       qa.push_back(e);
                    1:       qb.push_back(e);
                    default: qc.push_back(e);
                endcase
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        set_in(s, 1'b0, '0);
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL drive%0d_timeout: input %0d never accepted", s, d);
        end
    endtask

    task automatic drain(input int s);
        int n = 0;
        set_ordy(s, 1'b1);
        while (qsize(s) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_left", qsize(s), 0);
        chk("valid_after_drain", int'(out_vld(s)), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bin[10]  = '{6, 5, -6, 40000, -40000, 0, 32766, 32765, -32770, -32771};
        int bout[10] = '{2, 1, -1, 8191, -8192, 0, 8191, 8191, -8192, -8192};
        bit bsat[10] = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 1};

        set_in(0, 1'b0, '0); set_in(1, 1'b0, '0); set_in(2, 1'b0, '0);
        set_ordy(0, 1'b1); set_ordy(1, 1'b1); set_ordy(2, 1'b0);

        // Reset state and release
        #2;
        chk("rst_input_ready", int'(ifa.input_ready), 0);
        chk("rst_output_valid", int'(ifa.output_valid), 0);
        chk("rst_output_data", int'(ifa.output_data), 0);
        chk("rst_output_last", int'(ifa.output_last), 0);
        chk("rst_output_sat", int'(ifa.output_sat), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("ready_before_first_edge", int'(ifc.input_ready), 0);
        @(posedge clk);
        #1 chk("ready_after_first_edge", int'(ifc.input_ready), 1);

        // Defaults: ReLU then round-shift by 2
        drive(0, -800, 0, 0, 0);
        drive(0, -1200, 0, 0, 0);
        drive(0, 8400, 2100, 1, 0);
        drain(0);

        // No ReLU: rounding direction and saturation boundaries
        for (int i = 0; i < 10; i++)
            drive(1, 28'(bin[i]), 14'(bout[i]), (i % 3 == 2), bsat[i]);
        drain(1);

        // Backpressure with SHIFT=0
        for (int i = 1; i <= 4; i++)
            drive(2, 28'(i), 14'(i), (i == 3), 0);
        @(negedge clk);
        chk("ready_when_full", int'(ifc.input_ready), 0);
        fork
            drive(2, 5, 5, 0, 0);
            begin
                repeat (2) @(posedge clk);
                #1 set_ordy(2, 1'b1);
                @(negedge clk);
                chk("ready_before_pop", int'(ifc.input_ready), 0);
                @(negedge clk);
                chk("ready_after_pop", int'(ifc.input_ready), 1);
            end
        join
        drive(2, 6, 6, 1, 0);
        drain(2);

        // Random valid/ready over four vectors
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    drive(2, 28'(101 + i), 14'(101 + i), (i % 3 == 2), 0);
                end
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    set_ordy(2, 1'($urandom_range(0, 1)));
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain(2);

        // Asynchronous reset with three entries queued and group counter at 1
        drive(2, 301, 301, 0, 0);
        drain(2);
        set_ordy(2, 1'b0);
        drive(2, 302, 302, 0, 0);
        drive(2, 303, 303, 1, 0);
        drive(2, 304, 304, 0, 0);
        #2 rst = 1'b0;
        qa.delete(); qb.delete(); qc.delete();
        #1;
        chk("async_rst_valid", int'(ifc.output_valid), 0);
        chk("async_rst_data", int'(ifc.output_data), 0);
        chk("async_rst_last", int'(ifc.output_last), 0);
        chk("async_rst_ready", int'(ifc.input_ready), 0);
        set_ordy(2, 1'b1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_rerelease", int'(ifc.input_ready), 1);
        drive(2, 401, 401, 0, 0);
        drive(2, 402, 402, 0, 0);
        drive(2, 403, 403, 1, 0);
        drain(2);

        // Same-edge push and pop with two entries held
        set_ordy(2, 1'b0);
        drive(2, 501, 501, 0, 0);
        drive(2, 502, 502, 0, 0);
        set_ordy(2, 1'b1);
        drive(2, 503, 503, 1, 0);
        set_ordy(2, 1'b0);
        @(negedge clk);
        chk("ready_after_push_pop", int'(ifc.input_ready), 1);
        chk("valid_after_push_pop", int'(ifc.output_valid), 1);
        @(posedge clk);
        #1;
        drive(2, 504, 504, 0, 0);
        drive(2, 505, 505, 0, 0);
        @(negedge clk);
        chk("full_after_two_more", int'(ifc.input_ready), 0);
        @(posedge clk);
        #1;
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
